axis_byte_upsizer: RTL and testbench

- Packs an 8-bit AXI Stream byte stream (e.g. UART Rx output) into a wide AXI Stream word stream of OUT_BYTES bytes.
- Sits between a byte-oriented source and wide consumers such as a FIFO or DMA.
- Flushes partial words on tlast with the correct per-byte tkeep.
- Both sides use the team's axis_interface: Sink modport in, Source modport out.

---
 rtl/axis_byte_upsizer_if.sv | 28 ++
 rtl/axis_byte_upsizer.sv | 152 +++++++++++++++
 tb/tb_axis_byte_upsizer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_upsizer_if.sv
// axis_interface: AXI Stream bundle shared by byte and word sides of the upsizer.
// Source drives payload and tvalid; Sink drives tready.
interface axis_interface #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport Source (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport Sink (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_byte_upsizer.sv
// axis_byte_upsizer: packs an 8-bit AXI Stream into OUT_BYTES-wide little-endian words.
// Optional AXIS_BYTE_UPSIZER_ID_FLUSH_EN: flush a partial word when tid/tdest changes mid-word.
module axis_byte_upsizer #(
  parameter int OUT_BYTES  = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input logic           clk,
  input logic           reset,
  axis_interface.Sink   s_axis,
  axis_interface.Source m_axis
);
  localparam int CNT_W = $clog2(OUT_BYTES);
  localparam int ACC_W = 8 * (OUT_BYTES - 1);
  localparam int OUT_W = 8 * OUT_BYTES;

  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic [ID_WIDTH-1:0]   id_lat;
  logic [DEST_WIDTH-1:0] dest_lat;

  logic [OUT_W-1:0]      out_data;
  logic [OUT_BYTES-1:0]  out_keep;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;
  logic                  out_valid;

  logic                  out_free;
  logic                  s_ready;
  logic                  accept;
  logic                  take_byte;
  logic                  word_done;
  logic [OUT_W-1:0]      pack_data;
  logic [OUT_BYTES-1:0]  pack_keep;
  logic [ID_WIDTH-1:0]   word_id;
  logic [DEST_WIDTH-1:0] word_dest;

  // The out register may be refilled in the same cycle its word is taken.
  assign out_free  = !out_valid || m_axis.tready;
  assign accept    = s_axis.tvalid && s_ready;
  assign take_byte = accept && s_axis.tkeep[0];
  assign word_done = accept &&
                     (s_axis.tlast || (s_axis.tkeep[0] && cnt == CNT_W'(OUT_BYTES - 1)));
  assign word_id   = (cnt == '0) ? s_axis.tid   : id_lat;
  assign word_dest = (cnt == '0) ? s_axis.tdest : dest_lat;

`ifdef AXIS_BYTE_UPSIZER_ID_FLUSH_EN
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state;
  logic   id_change;

  assign id_change = s_axis.tvalid && (cnt != '0) &&
                     ((s_axis.tid != id_lat) || (s_axis.tdest != dest_lat));
  assign s_ready   = !reset && out_free && (state == IDLE) && !id_change;
`else
  assign s_ready   = !reset && out_free;
`endif

  // Held bytes followed by the incoming byte (if it carries data), unused lanes zeroed.
  always_comb begin
    pack_data = '0;
    pack_keep = '0;
    for (int k = 0; k < OUT_BYTES - 1; k++) begin
      if (k < int'(cnt)) begin
        pack_data[8*k +: 8] = acc[8*k +: 8];
        pack_keep[k]        = 1'b1;
      end
    end
    if (take_byte) begin
      pack_data[8*int'(cnt) +: 8] = s_axis.tdata;
      pack_keep[cnt]              = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      id_lat    <= '0;
      dest_lat  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      out_dest  <= '0;
      out_user  <= '0;
      out_valid <= 1'b0;
`ifdef AXIS_BYTE_UPSIZER_ID_FLUSH_EN
      state     <= IDLE;
`endif
    end else begin
      if (m_axis.tvalid && m_axis.tready) begin
        out_valid <= 1'b0;
      end

      if (word_done) begin
        out_data  <= pack_data;
        out_keep  <= pack_keep;
        out_last  <= s_axis.tlast;
        out_id    <= word_id;
        out_dest  <= word_dest;
        out_user  <= s_axis.tuser;
        out_valid <= 1'b1;
        cnt       <= '0;
      end else if (take_byte) begin
        acc[8*cnt +: 8] <= s_axis.tdata;
        cnt             <= cnt + CNT_W'(1);
        if (cnt == '0) begin
          id_lat   <= s_axis.tid;
          dest_lat <= s_axis.tdest;
        end
      end

`ifdef AXIS_BYTE_UPSIZER_ID_FLUSH_EN
      // The mismatching beat is held off until the partial word has gone out.
      case (state)
        IDLE: begin
          if (id_change) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_data  <= pack_data;
            out_keep  <= pack_keep;
            out_last  <= 1'b0;
            out_id    <= id_lat;
            out_dest  <= dest_lat;
            out_user  <= '0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tlast  = out_last;
  assign m_axis.tid    = out_id;
  assign m_axis.tdest  = out_dest;
  assign m_axis.tuser  = out_user;
endmodule

// File: tb/tb_axis_byte_upsizer.sv
// tb_axis_byte_upsizer: directed and randomized checks of axis_byte_upsizer
// against a byte-list packing model; honours AXIS_BYTE_UPSIZER_ID_FLUSH_EN.
`timescale 1ns/1ps
module tb_axis_byte_upsizer;
  localparam int OB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_interface #(.DATA_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_if ();
  axis_interface #(.DATA_WIDTH(8*OB), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) m_if ();

  axis_byte_upsizer #(.OUT_BYTES(OB), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  typedef struct {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [7:0] id;
    logic [7:0] dest;
    logic       user;
  } beat_t;

  typedef struct {
    logic [8*OB-1:0] data;
    logic [OB-1:0]   keep;
    logic            last;
    logic [7:0]      id;
    logic [7:0]      dest;
    logic            user;
  } word_t;

  int    total = 0;
  int    bad = 0;
  beat_t beats[$];
  word_t exp_q[$];
  word_t got_q[$];
  int    unstable;
  bit    drv_to;
  bit    col_to;

`ifdef AXIS_BYTE_UPSIZER_ID_FLUSH_EN
  localparam bit ID_FLUSH = 1'b1;
`else
  localparam bit ID_FLUSH = 1'b0;
`endif

  function automatic word_t mk(logic [8*OB-1:0] d, int n, logic [7:0] id, logic [7:0] dest,
                               logic last, logic user);
    word_t w;
    w.data = d;
    w.keep = OB'((1 << n) - 1);
    w.last = last;
    w.id   = id;
    w.dest = dest;
    w.user = user;
    return w;
  endfunction

  function automatic logic [8*OB-1:0] keep_mask(logic [OB-1:0] k);
    logic [8*OB-1:0] m = '0;
    for (int b = 0; b < OB; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic beat_t mkb(logic [7:0] d, logic k, logic l, logic [7:0] id);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.id = id; b.dest = 8'd3; b.user = d[0];
    return b;
  endfunction

  // Reference: bytes pile up in a list; a word leaves when full, on tlast, or on an id switch.
  task automatic build_expected();
    logic [8*OB-1:0] hword = '0;
    int              n = 0;
    logic [7:0]      wid = '0;
    logic [7:0]      wdest = '0;
    exp_q.delete();
    foreach (beats[i]) begin
      beat_t b = beats[i];
      if (ID_FLUSH && n > 0 && (b.id != wid || b.dest != wdest)) begin
        exp_q.push_back(mk(hword, n, wid, wdest, 1'b0, 1'b0));
        n = 0; hword = '0;
      end
      if (n == 0) begin
        wid = b.id; wdest = b.dest;
      end
      if (b.keep) begin
        hword[8*n +: 8] = b.data;
        n++;
        if (n == OB || b.last) begin
          exp_q.push_back(mk(hword, n, wid, wdest, b.last, b.user));
          n = 0; hword = '0;
        end
      end else if (b.last) begin
        exp_q.push_back(mk(hword, n, wid, wdest, 1'b1, b.user));
        n = 0; hword = '0;
      end
    end
  endtask

  task automatic send_beats(input int max_gap);
    drv_to = 1'b0;
    foreach (beats[i]) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      int waited = 0;
      repeat (gap) @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = beats[i].data;
      s_if.tkeep  = beats[i].keep;
      s_if.tlast  = beats[i].last;
      s_if.tid    = beats[i].id;
      s_if.tdest  = beats[i].dest;
      s_if.tuser  = beats[i].user;
      #1;
      while (!s_if.tready && waited < 500) begin
        @(negedge clk); #1; waited++;
      end
      if (!s_if.tready) begin
        drv_to = 1'b1;
        s_if.tvalid = 1'b0;
        return;
      end
      @(negedge clk);
      s_if.tvalid = 1'b0;
    end
  endtask

  task automatic collect(input int n, input int ready_pct);
    int    cycles = 0;
    bit    stalled = 1'b0;
    word_t prev;
    word_t w;
    col_to = 1'b0;
    unstable = 0;
    got_q.delete();
    while (got_q.size() < n && cycles < 3000) begin
      @(negedge clk);
      m_if.tready = ($urandom_range(99, 0) < ready_pct);
      #1;
      w.data = m_if.tdata; w.keep = m_if.tkeep; w.last = m_if.tlast;
      w.id = m_if.tid; w.dest = m_if.tdest; w.user = m_if.tuser;
      if (stalled && (!m_if.tvalid || w != prev)) unstable++;
      stalled = 1'b0;
      if (m_if.tvalid) begin
        if (m_if.tready) got_q.push_back(w);
        else begin
          stalled = 1'b1;
          prev = w;
        end
      end
      cycles++;
    end
    if (got_q.size() < n) col_to = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%0h exp=0", m_if.tvalid); end
    total++; if (m_if.tdata !== '0) begin bad++; $display("[TB] FAIL reset_tdata got=%0h exp=0", m_if.tdata); end
    total++; if (m_if.tkeep !== '0 || m_if.tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_keep_last got=%0h/%0h exp=0/0", m_if.tkeep, m_if.tlast); end
    total++; if (m_if.tid !== '0 || m_if.tdest !== '0 || m_if.tuser !== '0) begin bad++; $display("[TB] FAIL reset_sideband got=%0h/%0h/%0h exp=0", m_if.tid, m_if.tdest, m_if.tuser); end
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_tready got=%0h exp=0", s_if.tready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_s_tready got=%0h exp=1", s_if.tready); end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = bytes[i]; s_if.tkeep = 1'b1;
      s_if.tlast = (i == 3); s_if.tid = 8'h07; s_if.tdest = 8'h09; s_if.tuser = 1'b1;
      #1;
      total++; if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_pre byte=%0d got ready=%0h valid=%0h exp 1/0", i, s_if.tready, m_if.tvalid); end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    #1;
    total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h44332211) begin bad++; $display("[TB] FAIL single_word got v=%0h d=%0h exp v=1 d=44332211", m_if.tvalid, m_if.tdata); end
    total++; if (m_if.tkeep !== 4'hF || m_if.tlast !== 1'b1 || m_if.tid !== 8'h07 || m_if.tdest !== 8'h09) begin bad++; $display("[TB] FAIL single_side got k=%0h l=%0h id=%0h de=%0h exp F/1/7/9", m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest); end
    @(negedge clk); #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%0h exp=0", m_if.tvalid); end
  endtask

  task automatic test_two_words();
    beats.delete();
    for (int i = 1; i <= 6; i++) beats.push_back(mkb(8'(i), 1'b1, i == 6, 8'd1));
    build_expected();
    @(negedge clk);
    fork
      send_beats(0);
      collect(2, 100);
    join
    total++; if (drv_to || col_to || got_q.size() != 2) begin bad++; $display("[TB] FAIL two_count got=%0d exp=2 (timeouts %0d/%0d)", got_q.size(), drv_to, col_to); end
    else begin
      total++; if (got_q[0].data !== 32'h04030201 || got_q[0].keep !== 4'hF || got_q[0].last !== 1'b0) begin bad++; $display("[TB] FAIL two_w0 got %0h/%0h/%0h exp 04030201/F/0", got_q[0].data, got_q[0].keep, got_q[0].last); end
      total++; if (got_q[1].data[15:0] !== 16'h0605 || got_q[1].keep !== 4'h3 || got_q[1].last !== 1'b1) begin bad++; $display("[TB] FAIL two_w1 got %0h/%0h/%0h exp 0605/3/1", got_q[1].data[15:0], got_q[1].keep, got_q[1].last); end
      total++; if (got_q[1] != exp_q[1] && (got_q[1].data & keep_mask(exp_q[1].keep)) !== exp_q[1].data) begin bad++; $display("[TB] FAIL two_model got %0h exp %0h", got_q[1].data, exp_q[1].data); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    int          w = 0;
    beats.delete();
    for (int i = 0; i < 8; i++) beats.push_back(mkb(8'hA0 + 8'(i), 1'b1, i == 7, 8'd1));
    build_expected();
    @(negedge clk);
    m_if.tready = 1'b0;
    fork
      send_beats(0);
      begin
        #1;
        while (!m_if.tvalid && w < 100) begin @(negedge clk); #1; w++; end
        first = m_if.tdata;
        total++; if (first !== 32'hA3A2A1A0) begin bad++; $display("[TB] FAIL bp_first got=%0h exp=a3a2a1a0", first); end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk); #1;
          total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hA3A2A1A0 || s_if.tready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold cyc=%0d got v=%0h d=%0h sr=%0h exp 1/a3a2a1a0/0", c, m_if.tvalid, m_if.tdata, s_if.tready); end
        end
        collect(2, 100);
      end
    join
    total++; if (drv_to || col_to || got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if ((got_q[i].data & keep_mask(exp_q[i].keep)) !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep || got_q[i].last !== exp_q[i].last) begin bad++; $display("[TB] FAIL bp_word%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got_q[i].data, got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last); end
    end
  endtask

  task automatic test_null_beats();
    beats.delete();
    beats.push_back(mkb(8'hAA, 1'b1, 1'b0, 8'd1));
    beats.push_back(mkb(8'hBB, 1'b0, 1'b0, 8'd1));
    beats.push_back(mkb(8'hCC, 1'b1, 1'b1, 8'd1));
    beats.push_back(mkb(8'hDD, 1'b0, 1'b1, 8'd5));
    @(negedge clk);
    fork
      send_beats(1);
      collect(2, 80);
    join
    total++; if (drv_to || col_to || got_q.size() != 2) begin bad++; $display("[TB] FAIL null_count got=%0d exp=2", got_q.size()); end
    else begin
      total++; if (got_q[0].data[15:0] !== 16'hCCAA || got_q[0].keep !== 4'h3 || got_q[0].last !== 1'b1) begin bad++; $display("[TB] FAIL null_w0 got %0h/%0h/%0h exp ccaa/3/1", got_q[0].data[15:0], got_q[0].keep, got_q[0].last); end
      total++; if (got_q[1].keep !== 4'h0 || got_q[1].last !== 1'b1 || got_q[1].id !== 8'd5) begin bad++; $display("[TB] FAIL null_lone got k=%0h l=%0h id=%0h exp 0/1/5", got_q[1].keep, got_q[1].last, got_q[1].id); end
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    beats.delete();
    beats.push_back(mkb(8'hE1, 1'b1, 1'b0, 8'd1));
    beats.push_back(mkb(8'hE2, 1'b1, 1'b0, 8'd1));
    @(negedge clk);
    m_if.tready = 1'b1;
    send_beats(0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back(mkb(8'h10 + 8'(i), 1'b1, 1'b0, 8'd1));
    fork
      send_beats(0);
      collect(1, 100);
    join
    total++; if (drv_to || col_to || got_q.size() != 1) begin bad++; $display("[TB] FAIL rst_count got=%0d exp=1", got_q.size()); end
    else begin
      total++; if (got_q[0].data !== 32'h13121110 || got_q[0].keep !== 4'hF) begin bad++; $display("[TB] FAIL rst_word got %0h/%0h exp 13121110/F", got_q[0].data, got_q[0].keep); end
    end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (m_if.tvalid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL rst_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_id_change();
    beats.delete();
    beats.push_back(mkb(8'h51, 1'b1, 1'b0, 8'd1));
    beats.push_back(mkb(8'h52, 1'b1, 1'b0, 8'd1));
    beats.push_back(mkb(8'h53, 1'b1, 1'b0, 8'd2));
    beats.push_back(mkb(8'h54, 1'b1, 1'b1, 8'd2));
    @(negedge clk);
    fork
      send_beats(0);
      collect(ID_FLUSH ? 2 : 1, 100);
    join
    total++; if (drv_to || col_to || got_q.size() != (ID_FLUSH ? 2 : 1)) begin bad++; $display("[TB] FAIL id_count got=%0d exp=%0d", got_q.size(), ID_FLUSH ? 2 : 1); end
    else if (ID_FLUSH) begin
      total++; if (got_q[0].keep !== 4'h3 || got_q[0].id !== 8'd1 || got_q[0].last !== 1'b0 || got_q[0].data[15:0] !== 16'h5251) begin bad++; $display("[TB] FAIL id_w0 got k=%0h id=%0h l=%0h exp 3/1/0", got_q[0].keep, got_q[0].id, got_q[0].last); end
      total++; if (got_q[1].keep !== 4'h3 || got_q[1].id !== 8'd2 || got_q[1].last !== 1'b1 || got_q[1].data[15:0] !== 16'h5453) begin bad++; $display("[TB] FAIL id_w1 got k=%0h id=%0h l=%0h exp 3/2/1", got_q[1].keep, got_q[1].id, got_q[1].last); end
    end else begin
      total++; if (got_q[0].keep !== 4'hF || got_q[0].id !== 8'd1 || got_q[0].last !== 1'b1 || got_q[0].data !== 32'h54535251) begin bad++; $display("[TB] FAIL id_single got k=%0h id=%0h l=%0h d=%0h exp F/1/1/54535251", got_q[0].keep, got_q[0].id, got_q[0].last, got_q[0].data); end
    end
  endtask

  task automatic test_random();
    logic [7:0] cur_id = 8'd1;
    for (int r = 0; r < 4; r++) begin
      beats.delete();
      for (int i = 0; i < 40; i++) begin
        beat_t b;
        if ($urandom_range(4, 0) == 0) cur_id = (cur_id == 8'd1) ? 8'd2 : 8'd1;
        b.data = 8'($urandom);
        b.keep = ($urandom_range(9, 0) != 0);
        b.last = ($urandom_range(6, 0) == 0) || (i == 39);
        b.id   = cur_id;
        b.dest = 8'd3;
        b.user = 1'($urandom);
        beats.push_back(b);
      end
      build_expected();
      @(negedge clk);
      fork
        send_beats(2);
        collect(exp_q.size(), 60);
      join
      total++; if (drv_to || col_to || got_q.size() != exp_q.size() || unstable != 0) begin bad++; $display("[TB] FAIL rnd%0d_stream got n=%0d unstable=%0d exp n=%0d unstable=0", r, got_q.size(), unstable, exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if ((got_q[i].data & keep_mask(exp_q[i].keep)) !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep ||
            got_q[i].last !== exp_q[i].last || got_q[i].id !== exp_q[i].id ||
            got_q[i].dest !== exp_q[i].dest || got_q[i].user !== exp_q[i].user) begin
          bad++;
          $display("[TB] FAIL rnd%0d_word%0d got %0h/%0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h/%0h", r, i,
                   got_q[i].data, got_q[i].keep, got_q[i].last, got_q[i].id, got_q[i].user,
                   exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].id, exp_q[i].user);
        end
      end
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
    m_if.tready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_word();
    test_two_words();
    test_backpressure();
    test_null_beats();
    test_reset_mid();
    test_id_change();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
